mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Controls the multi-cycle multiply/divide unit (MDU) from the execute stage of the 5-stage RV32 pipeline.
- Accepts M-extension ops from execute, latches operands, starts the MDU and stalls the pipeline until the result is ready.
- Holds the result until the pipeline accepts it, and cancels the in-flight op on a branch/jump flush.
- Includes a watchdog that catches an MDU that never completes.

Parameters:
TIMEOUT_CYCLES, 64, max WAIT cycles before abort; >=2
CNT_W, 7, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
issue_valid_i  input  1  execute stage holds an M-ext instruction (mul_en)
issue_funct3_i  input  3  M-ext op select (000 MUL .. 111 REMU)
issue_rd_i  input  5  destination register
issue_rs1_i  input  32  operand A
issue_rs2_i  input  32  operand B
flush_i  input  1  branch/jump flush of execute
wb_ready_i  input  1  pipeline can take result this cycle
stall_o  output  1  freeze fetch/decode/execute
mdu_start_o  output  1  one-cycle MDU start pulse
mdu_op_o  output  3  latched funct3
mdu_a_o  output  32  latched rs1
mdu_b_o  output  32  latched rs2
mdu_kill_o  output  1  one-cycle abort pulse to MDU
mdu_done_i  input  1  MDU result valid (single-cycle pulse)
mdu_result_i  input  32  MDU result
result_valid_o  output  1  result held for writeback
result_o  output  32  held result
result_rd_o  output  5  held destination
busy_o  output  1  state != IDLE
err_o  output  1  sticky watchdog error

Behaviour:
- Reset (rst=1 at posedge): state IDLE. All outputs 0, including latched operands, result, err_o and counter. Reset mid-operation discards the op; the MDU shares rst, so no kill is issued.
- States: IDLE, START, WAIT, HOLD.
- IDLE:
  - If issue_valid_i && !flush_i: latch funct3, rd, rs1, rs2 into mdu_op_o, result_rd_o, mdu_a_o, mdu_b_o, then go to START.
  - Otherwise stay in IDLE.
- START: mdu_start_o=1 for exactly this cycle; clear watchdog counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On mdu_done_i: result_o<=mdu_result_i, go to HOLD.
  - If counter reaches TIMEOUT_CYCLES-1 with no done: set err_o, pulse mdu_kill_o next cycle, go to IDLE with no result.
- HOLD: result_valid_o=1. If wb_ready_i, go to IDLE and drop result_valid_o next cycle.
- stall_o (combinational) = (IDLE && issue_valid_i && !flush_i) || START || WAIT || (HOLD && !wb_ready_i). The issuing instruction leaves execute in the same cycle its result is accepted.
- Minimum latency, issue to result_valid_o: 2 cycles + MDU latency (done in the first WAIT cycle gives result_valid_o in cycle 3).
- Flush:
  - In START or WAIT: mdu_kill_o=1 next cycle, go to IDLE, no result.
  - In HOLD: drop result, go to IDLE.
  - Flush beats mdu_done_i and wb_ready_i in the same cycle.
  - Flush in IDLE blocks acceptance.
- Issues are accepted only in IDLE. A back-to-back M-op is accepted the cycle after HOLD exits.
- mdu_done_i outside WAIT is ignored.
- err_o is cleared only by rst; the block stays operational after an error.

Optional Feature:
- Macro MDU_FASTPATH_EN.
- Defined: in IDLE, an accepted op with issue_rs2_i==0 and funct3 DIV/DIVU goes directly to HOLD with result_o=32'hFFFFFFFF. REM/REMU with rs2==0 goes to HOLD with result_o=issue_rs1_i. No mdu_start_o is issued; latency is 1 cycle.
- Undefined: every op, including divide-by-zero, goes through START/WAIT.

Test Plan:
- MUL 7*6, MDU model done after 3 WAIT cycles with 42 -> mdu_start_o one pulse at cycle 1; result_valid_o=1, result_o=42, rd echoed at cycle 5; stall_o high cycles 0-4, low at cycle 5 with wb_ready_i=1.
- Result in HOLD with wb_ready_i=0 for 4 cycles -> result_valid_o and result_o=42 stay stable; stall_o high until wb_ready_i=1, then IDLE.
- flush_i in the 2nd WAIT cycle, with mdu_done_i forced in the same cycle -> mdu_kill_o one pulse, no result_valid_o, busy_o=0 next cycle.
- MDU never asserts done, TIMEOUT_CYCLES=8 -> err_o=1 after 8 WAIT cycles, kill pulse, IDLE. A following MUL 3*3 completes normally with result 9.
- DIVU 100/0 -> with MDU_FASTPATH_EN: result_o=FFFFFFFF one cycle after issue, no start. Without it: mdu_start_o fires and the MDU result passes through.
- rst asserted mid-WAIT -> next cycle all outputs 0 and state IDLE; later mdu_done_i is ignored.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Execute-stage sequencer for the multi-cycle multiply/divide unit: issue, stall, hold, flush and watchdog.
// Optional define MDU_FASTPATH_EN resolves divide/remainder by zero in one cycle without starting the MDU.
module mdu_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid_i,
  input  logic [2:0]  issue_funct3_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [31:0] issue_rs1_i,
  input  logic [31:0] issue_rs2_i,
  input  logic        flush_i,
  input  logic        wb_ready_i,
  output logic        stall_o,
  output logic        mdu_start_o,
  output logic [2:0]  mdu_op_o,
  output logic [31:0] mdu_a_o,
  output logic [31:0] mdu_b_o,
  output logic        mdu_kill_o,
  input  logic        mdu_done_i,
  input  logic [31:0] mdu_result_i,
  output logic        result_valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  result_rd_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             latch_en, res_load, kill_n, err_set, cnt_clr, cnt_inc;
  logic [31:0]      res_n;

  always_comb begin
    state_n  = state;
    latch_en = 1'b0;
    res_load = 1'b0;
    res_n    = mdu_result_i;
    kill_n   = 1'b0;
    err_set  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (issue_valid_i && !flush_i) begin
          latch_en = 1'b1;
          state_n  = START;
`ifdef MDU_FASTPATH_EN
          // funct3[2] selects the divide group, funct3[1] selects remainder
          if (issue_rs2_i == 32'd0 && issue_funct3_i[2]) begin
            state_n  = HOLD;
            res_load = 1'b1;
            res_n    = issue_funct3_i[1] ? issue_rs1_i : 32'hFFFF_FFFF;
          end
`endif
        end
      end
      START: begin
        cnt_clr = 1'b1;
        if (flush_i) begin
          kill_n  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        cnt_inc = 1'b1;
        // flush wins over a simultaneous done; done wins over the watchdog
        if (flush_i) begin
          kill_n  = 1'b1;
          state_n = IDLE;
        end else if (mdu_done_i) begin
          res_load = 1'b1;
          state_n  = HOLD;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_set = 1'b1;
          kill_n  = 1'b1;
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (flush_i || wb_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign mdu_start_o    = (state == START);
  assign result_valid_o = (state == HOLD);
  assign busy_o         = (state != IDLE);
  assign stall_o        = ((state == IDLE) && issue_valid_i && !flush_i) ||
                          (state == START) || (state == WAIT) ||
                          ((state == HOLD) && !wb_ready_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mdu_kill_o  <= 1'b0;
      err_o       <= 1'b0;
      mdu_op_o    <= '0;
      mdu_a_o     <= '0;
      mdu_b_o     <= '0;
      result_rd_o <= '0;
      result_o    <= '0;
    end else begin
      state      <= state_n;
      mdu_kill_o <= kill_n;
      if (err_set) err_o <= 1'b1;
      if (cnt_clr) cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (latch_en) begin
        mdu_op_o    <= issue_funct3_i;
        mdu_a_o     <= issue_rs1_i;
        mdu_b_o     <= issue_rs2_i;
        result_rd_o <= issue_rd_i;
      end
      if (res_load) result_o <= res_n;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed issue/wait/hold/flush/timeout/reset sequences.
module tb_mdu_sequencer;

  logic        clk;
  logic        rst;
  logic        issue_valid_i;
  logic [2:0]  issue_funct3_i;
  logic [4:0]  issue_rd_i;
  logic [31:0] issue_rs1_i;
  logic [31:0] issue_rs2_i;
  logic        flush_i;
  logic        wb_ready_i;
  logic        stall_o;
  logic        mdu_start_o;
  logic [2:0]  mdu_op_o;
  logic [31:0] mdu_a_o;
  logic [31:0] mdu_b_o;
  logic        mdu_kill_o;
  logic        mdu_done_i;
  logic [31:0] mdu_result_i;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic [4:0]  result_rd_o;
  logic        busy_o;
  logic        err_o;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mdu_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid_i  (issue_valid_i),
    .issue_funct3_i (issue_funct3_i),
    .issue_rd_i     (issue_rd_i),
    .issue_rs1_i    (issue_rs1_i),
    .issue_rs2_i    (issue_rs2_i),
    .flush_i        (flush_i),
    .wb_ready_i     (wb_ready_i),
    .stall_o        (stall_o),
    .mdu_start_o    (mdu_start_o),
    .mdu_op_o       (mdu_op_o),
    .mdu_a_o        (mdu_a_o),
    .mdu_b_o        (mdu_b_o),
    .mdu_kill_o     (mdu_kill_o),
    .mdu_done_i     (mdu_done_i),
    .mdu_result_i   (mdu_result_i),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .result_rd_o    (result_rd_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    issue_valid_i  = 1'b1;
    issue_funct3_i = f3;
    issue_rd_i     = rd;
    issue_rs1_i    = a;
    issue_rs2_i    = b;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_stall"},  32'(stall_o), 32'd0);
    check({pfx, "_start"},  32'(mdu_start_o), 32'd0);
    check({pfx, "_op"},     32'(mdu_op_o), 32'd0);
    check({pfx, "_a"},      mdu_a_o, 32'd0);
    check({pfx, "_b"},      mdu_b_o, 32'd0);
    check({pfx, "_kill"},   32'(mdu_kill_o), 32'd0);
    check({pfx, "_rvalid"}, 32'(result_valid_o), 32'd0);
    check({pfx, "_result"}, result_o, 32'd0);
    check({pfx, "_rd"},     32'(result_rd_o), 32'd0);
    check({pfx, "_busy"},   32'(busy_o), 32'd0);
    check({pfx, "_err"},    32'(err_o), 32'd0);
  endtask

  // Accepted results are popped from the scoreboard in order
  always @(negedge clk) begin
    if (!rst && result_valid_o && wb_ready_i && !flush_i) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result", result_o, e.res);
        check("sb_rd", 32'(result_rd_o), 32'(e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    issue_valid_i = 1'b0; issue_funct3_i = '0; issue_rd_i = '0;
    issue_rs1_i = '0; issue_rs2_i = '0;
    flush_i = 1'b0; wb_ready_i = 1'b0; mdu_done_i = 1'b0; mdu_result_i = '0;
    repeat (2) next_cyc();
    rst = 1'b0;
    mid();
    check_zero("reset");

    // MUL 7*6, done in the third WAIT cycle
    next_cyc();
    wb_ready_i = 1'b1;
    issue(3'd0, 5'd5, 32'd7, 32'd6);
    sb_q.push_back('{res: 32'd42, rd: 5'd5});
    mid();
    check("t1_stall_c0", 32'(stall_o), 32'd1);
    check("t1_start_c0", 32'(mdu_start_o), 32'd0);
    next_cyc();
    issue_valid_i = 1'b0;
    mid();
    check("t1_start_c1", 32'(mdu_start_o), 32'd1);
    check("t1_a", mdu_a_o, 32'd7);
    check("t1_b", mdu_b_o, 32'd6);
    check("t1_op", 32'(mdu_op_o), 32'd0);
    check("t1_stall_c1", 32'(stall_o), 32'd1);
    next_cyc();
    mid();
    check("t1_start_c2", 32'(mdu_start_o), 32'd0);
    check("t1_stall_c2", 32'(stall_o), 32'd1);
    next_cyc();
    mid();
    check("t1_stall_c3", 32'(stall_o), 32'd1);
    next_cyc();
    mdu_done_i = 1'b1; mdu_result_i = 32'd42;
    mid();
    check("t1_stall_c4", 32'(stall_o), 32'd1);
    check("t1_rvalid_c4", 32'(result_valid_o), 32'd0);
    next_cyc();
    mdu_done_i = 1'b0; mdu_result_i = '0;
    mid();
    check("t1_rvalid_c5", 32'(result_valid_o), 32'd1);
    check("t1_result_c5", result_o, 32'd42);
    check("t1_rd_c5", 32'(result_rd_o), 32'd5);
    check("t1_stall_c5", 32'(stall_o), 32'd0);
    next_cyc();
    mid();
    check("t1_busy_c6", 32'(busy_o), 32'd0);
    check("t1_rvalid_c6", 32'(result_valid_o), 32'd0);

    // Minimum latency, then held result with writeback back-pressure
    next_cyc();
    wb_ready_i = 1'b0;
    issue(3'd0, 5'd7, 32'd7, 32'd6);
    sb_q.push_back('{res: 32'd42, rd: 5'd7});
    next_cyc();
    issue_valid_i = 1'b0;
    next_cyc();
    mdu_done_i = 1'b1; mdu_result_i = 32'd42;
    next_cyc();
    mdu_done_i = 1'b0; mdu_result_i = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("t2_rvalid_hold", 32'(result_valid_o), 32'd1);
      check("t2_result_hold", result_o, 32'd42);
      check("t2_stall_hold", 32'(stall_o), 32'd1);
      next_cyc();
    end
    wb_ready_i = 1'b1;
    mid();
    check("t2_stall_accept", 32'(stall_o), 32'd0);
    check("t2_rvalid_accept", 32'(result_valid_o), 32'd1);
    next_cyc();
    mid();
    check("t2_busy_after", 32'(busy_o), 32'd0);

    // Flush in the second WAIT cycle beats a simultaneous done
    next_cyc();
    issue(3'd4, 5'd3, 32'd100, 32'd7);
    next_cyc();
    issue_valid_i = 1'b0;
    next_cyc();
    next_cyc();
    flush_i = 1'b1; mdu_done_i = 1'b1; mdu_result_i = 32'd14;
    mid();
    check("t3_busy_wait2", 32'(busy_o), 32'd1);
    check("t3_kill_wait2", 32'(mdu_kill_o), 32'd0);
    next_cyc();
    flush_i = 1'b0; mdu_done_i = 1'b0;
    mid();
    check("t3_kill", 32'(mdu_kill_o), 32'd1);
    check("t3_busy", 32'(busy_o), 32'd0);
    check("t3_rvalid", 32'(result_valid_o), 32'd0);
    check("t3_stall", 32'(stall_o), 32'd0);
    next_cyc();
    mid();
    check("t3_kill_pulse_end", 32'(mdu_kill_o), 32'd0);

    // Flush in IDLE blocks acceptance
    next_cyc();
    issue(3'd0, 5'd2, 32'd1, 32'd1);
    flush_i = 1'b1;
    mid();
    check("t3_idle_flush_stall", 32'(stall_o), 32'd0);
    next_cyc();
    issue_valid_i = 1'b0; flush_i = 1'b0;
    mid();
    check("t3_idle_flush_busy", 32'(busy_o), 32'd0);
    check("t3_idle_flush_start", 32'(mdu_start_o), 32'd0);

    // Watchdog: MDU never completes
    next_cyc();
    issue(3'd0, 5'd1, 32'd5, 32'd5);
    next_cyc();
    issue_valid_i = 1'b0;
    mid();
    check("t4_start", 32'(mdu_start_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      next_cyc();
      mid();
      check("t4_err_waiting", 32'(err_o), 32'd0);
      check("t4_busy_waiting", 32'(busy_o), 32'd1);
    end
    next_cyc();
    mid();
    check("t4_err", 32'(err_o), 32'd1);
    check("t4_kill", 32'(mdu_kill_o), 32'd1);
    check("t4_busy", 32'(busy_o), 32'd0);
    check("t4_rvalid", 32'(result_valid_o), 32'd0);
    next_cyc();
    mid();
    check("t4_kill_pulse_end", 32'(mdu_kill_o), 32'd0);
    next_cyc();
    issue(3'd0, 5'd9, 32'd3, 32'd3);
    sb_q.push_back('{res: 32'd9, rd: 5'd9});
    next_cyc();
    issue_valid_i = 1'b0;
    next_cyc();
    mdu_done_i = 1'b1; mdu_result_i = 32'd9;
    next_cyc();
    mdu_done_i = 1'b0;
    mid();
    check("t4_after_rvalid", 32'(result_valid_o), 32'd1);
    check("t4_after_result", result_o, 32'd9);
    check("t4_err_sticky", 32'(err_o), 32'd1);
    next_cyc();

    // DIVU 100/0
`ifdef MDU_FASTPATH_EN
    issue(3'd5, 5'd4, 32'd100, 32'd0);
    sb_q.push_back('{res: 32'hFFFF_FFFF, rd: 5'd4});
    mid();
    check("t5_stall_c0", 32'(stall_o), 32'd1);
    next_cyc();
    issue_valid_i = 1'b0;
    mid();
    check("t5_fast_rvalid", 32'(result_valid_o), 32'd1);
    check("t5_fast_start", 32'(mdu_start_o), 32'd0);
    check("t5_fast_result", result_o, 32'hFFFF_FFFF);
    next_cyc();
    issue(3'd7, 5'd6, 32'd100, 32'd0);
    sb_q.push_back('{res: 32'd100, rd: 5'd6});
    next_cyc();
    issue_valid_i = 1'b0;
    mid();
    check("t5_remu_rvalid", 32'(result_valid_o), 32'd1);
    check("t5_remu_result", result_o, 32'd100);
    next_cyc();
`else
    issue(3'd5, 5'd4, 32'd100, 32'd0);
    sb_q.push_back('{res: 32'hFFFF_FFFF, rd: 5'd4});
    next_cyc();
    issue_valid_i = 1'b0;
    mid();
    check("t5_start", 32'(mdu_start_o), 32'd1);
    next_cyc();
    mdu_done_i = 1'b1; mdu_result_i = 32'hFFFF_FFFF;
    next_cyc();
    mdu_done_i = 1'b0;
    mid();
    check("t5_rvalid", 32'(result_valid_o), 32'd1);
    check("t5_result", result_o, 32'hFFFF_FFFF);
    next_cyc();
`endif
    mid();
    check("t5_busy_after", 32'(busy_o), 32'd0);

    // Reset in the middle of WAIT, late done ignored
    next_cyc();
    issue(3'd1, 5'd31, 32'h1234, 32'h55);
    next_cyc();
    issue_valid_i = 1'b0;
    next_cyc();
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    mid();
    check_zero("t6_rst");
    next_cyc();
    mdu_done_i = 1'b1; mdu_result_i = 32'hDEAD;
    mid();
    check("t6_busy_done", 32'(busy_o), 32'd0);
    next_cyc();
    mdu_done_i = 1'b0;
    mid();
    check("t6_rvalid", 32'(result_valid_o), 32'd0);
    check("t6_result", result_o, 32'd0);
    check("t6_busy", 32'(busy_o), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
